// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the single-cycle RISC-V core:
//               major opcodes, the canonical NOP and the fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory request/acknowledge bus. The fetch stage
//               is the master; the instruction memory is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_calc
// Description : Combinational next-PC selection. A taken branch (branch and
//               zero) adds the sign-extended byte offset, otherwise the PC
//               advances by 4. Targets not on a word boundary are flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc (
    input  wire logic [31:0] pc,
    input  wire logic        branch,
    input  wire logic        zero,
    input  wire logic [31:0] branch_offset,
    output logic      [31:0] target,
    output logic             misalign
);

    logic w_taken;

    // Modulo-2^32 adds: wrap past 32'hFFFF_FFFC and negative offsets are intended.
    always_comb begin
        w_taken  = branch & zero;
        target   = w_taken ? (pc + branch_offset) : (pc + 32'd4);
        misalign = |target[1:0];
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the PC, runs a req/ack
//               transaction to instruction memory, latches the returned word
//               and presents it until downstream accepts it. On retire the
//               next PC is selected from the branch decision; a misaligned
//               target raises a sticky error and parks the stage until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    instr_fetch_if.master    mem,
    input  wire logic        stall,
    input  wire logic        branch,
    input  wire logic        zero,
    input  wire logic [31:0] branch_offset,
    output logic      [31:0] pc,
    output logic      [31:0] instr,
    output logic      [6:0]  opcode,
    output logic             instr_valid,
    output logic             fetch_err,
    output logic      [31:0] icount
);

    import riscv_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_icount;
    logic        r_fetch_err;

    logic        w_mem_req;
    logic        w_instr_valid;
    logic        w_load_instr;
    logic        w_retire;
    logic [31:0] w_target;
    logic        w_misalign;

    pc_next_calc u_pc_next_calc (
        .pc            (r_pc),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .target        (w_target),
        .misalign      (w_misalign)
    );

    // State register; reset always returns to IDLE, abandoning any open request.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the strobes that steer the datapath registers.
    always_comb begin
        w_state_next  = r_state;
        w_mem_req     = 1'b0;
        w_instr_valid = 1'b0;
        w_load_instr  = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = REQ;
            end
            REQ: begin
                w_mem_req = 1'b1;
                if (mem.mem_ack) begin
                    w_load_instr = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_instr_valid = 1'b1;
                if (!stall) begin
                    w_retire     = 1'b1;
                    w_state_next = w_misalign ? HALT : REQ;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture the fetched word, and on retire count it and move the PC.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc        <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_icount    <= 32'd0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_load_instr) begin
                r_instr <= mem.mem_rdata;
            end
            if (w_retire) begin
                r_icount <= r_icount + 32'd1;
                if (w_misalign) begin
                    r_fetch_err <= 1'b1;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = r_pc;
    assign pc           = r_pc;
    assign instr        = r_instr;
    assign opcode       = r_instr[6:0];
    assign instr_valid  = w_instr_valid;
    assign fetch_err    = r_fetch_err;
    assign icount       = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A driver plays the
//               instruction memory and downstream, keeps a transaction-level
//               model of the PC and retire count, and queues expectations; a
//               monitor compares DUT outputs against those queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock         = 1'b0;
    logic        reset_n       = 1'b0;
    logic        stall         = 1'b0;
    logic        branch        = 1'b0;
    logic        zero          = 1'b0;
    logic [31:0] branch_offset = 32'd0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] icount;

    instr_fetch_if mem_bus ();

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem           (mem_bus),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .pc            (pc),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .fetch_err     (fetch_err),
        .icount        (icount)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } issue_t;
    typedef struct { logic [31:0] pc; logic [31:0] icount; logic err; } retire_t;
    typedef struct { logic [31:0] addr; int len; } run_t;

    issue_t  issue_q[$];
    retire_t retire_q[$];
    run_t    req_q[$];
    int      valid_q[$];

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state
    logic [31:0] m_pc     = RST_PC;
    logic [31:0] m_icount = 32'd0;
    logic        m_halted = 1'b0;

    // Monitor state
    int          req_cnt  = 0;
    int          val_cnt  = 0;
    logic [31:0] req_addr = 32'd0;
    bit          pend     = 1'b0;
    bit          halted   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got empty expectation queue expected an entry", name);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic junk_ctrl();
        branch        = 1'($urandom_range(0, 1));
        zero          = 1'($urandom_range(0, 1));
        branch_offset = $urandom;
    endtask

    // One full instruction: wait for the request, ack after a delay, stall, retire.
    task automatic run_instr(input int ack_delay, input int stall_cycles, input logic [31:0] rdata,
                             input logic br, input logic z, input logic [31:0] off);
        int          waited;
        logic [31:0] tgt;
        waited = 0;
        while (mem_bus.mem_req !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        if (mem_bus.mem_req !== 1'b1) begin
            check("req_timeout", 32'(mem_bus.mem_req), 32'd1);
            return;
        end
        for (int i = 0; i < ack_delay; i++) begin
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = $urandom;
            step();
        end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = rdata;
        issue_q.push_back('{pc: m_pc, instr: rdata});
        req_q.push_back('{addr: m_pc, len: ack_delay + 1});
        step();
        for (int i = 0; i < stall_cycles; i++) begin
            stall             = 1'b1;
            mem_bus.mem_ack   = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata = $urandom;
            junk_ctrl();
            step();
        end
        stall             = 1'b0;
        branch            = br;
        zero              = z;
        branch_offset     = off;
        mem_bus.mem_ack   = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata = $urandom;
        tgt = (br && z) ? (m_pc + off) : (m_pc + 32'd4);
        m_icount = m_icount + 32'd1;
        if (tgt[1:0] != 2'b00) m_halted = 1'b1;
        else                   m_pc = tgt;
        retire_q.push_back('{pc: m_pc, icount: m_icount, err: m_halted});
        valid_q.push_back(stall_cycles + 1);
        step();
        mem_bus.mem_ack = 1'b0;
        stall           = 1'($urandom_range(0, 1));
        junk_ctrl();
    endtask

    // One-cycle reset; optional ack in the IDLE cycle that follows must be ignored.
    task automatic do_reset(input bit ack_in_idle);
        reset_n         = 1'b0;
        mem_bus.mem_ack = 1'b0;
        step();
        issue_q.delete();
        retire_q.delete();
        req_q.delete();
        valid_q.delete();
        m_pc     = RST_PC;
        m_icount = 32'd0;
        m_halted = 1'b0;
        reset_n           = 1'b1;
        mem_bus.mem_ack   = ack_in_idle;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        check("rst_pc",          pc,                         RST_PC);
        check("rst_instr",       instr,                      NOP);
        check("rst_opcode",      32'(opcode),                32'h13);
        check("rst_instr_valid", 32'(instr_valid),           32'd0);
        check("rst_mem_req",     32'(mem_bus.mem_req),       32'd0);
        check("rst_fetch_err",   32'(fetch_err),             32'd0);
        check("rst_icount",      icount,                     32'd0);
        step();
        mem_bus.mem_ack = 1'b0;
        check("idle_ack_ignored", instr,                     NOP);
        check("req_after_idle",   32'(mem_bus.mem_req),      32'd1);
        check("req_addr_reset",   mem_bus.mem_addr,          RST_PC);
    endtask

    // Monitor: compares observed outputs against queued expectations each cycle.
    initial begin : monitor
        issue_t  ei;
        retire_t er;
        run_t    rr;
        int      vl;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                req_cnt = 0;
                val_cnt = 0;
                pend    = 1'b0;
                halted  = 1'b0;
            end else begin
                if (halted) begin
                    check("halt_mem_req",     32'(mem_bus.mem_req), 32'd0);
                    check("halt_instr_valid", 32'(instr_valid),     32'd0);
                    check("halt_fetch_err",   32'(fetch_err),       32'd1);
                end
                if (pend) begin
                    pend = 1'b0;
                    if (retire_q.size() == 0) fail("retire_q");
                    else begin
                        er = retire_q.pop_front();
                        check("retire_pc",        pc,                   er.pc);
                        check("retire_icount",    icount,               er.icount);
                        check("retire_fetch_err", 32'(fetch_err),       32'(er.err));
                        check("retire_mem_req",   32'(mem_bus.mem_req), 32'(!er.err));
                        halted = er.err;
                    end
                end
                if (mem_bus.mem_req) begin
                    if (req_cnt == 0) req_addr = mem_bus.mem_addr;
                    else check("mem_addr_stable", mem_bus.mem_addr, req_addr);
                    req_cnt++;
                end else if (req_cnt > 0) begin
                    if (req_q.size() == 0) fail("req_q");
                    else begin
                        rr = req_q.pop_front();
                        check("req_addr", req_addr,     rr.addr);
                        check("req_len",  32'(req_cnt), 32'(rr.len));
                    end
                    req_cnt = 0;
                end
                if (instr_valid) begin
                    if (issue_q.size() == 0) fail("issue_q");
                    else begin
                        ei = issue_q[0];
                        check("issue_pc",     pc,          ei.pc);
                        check("issue_instr",  instr,       ei.instr);
                        check("issue_opcode", 32'(opcode), 32'(ei.instr[6:0]));
                        if (!stall) begin
                            void'(issue_q.pop_front());
                            pend = 1'b1;
                        end
                    end
                    val_cnt++;
                end else if (val_cnt > 0) begin
                    if (valid_q.size() == 0) fail("valid_q");
                    else begin
                        vl = valid_q.pop_front();
                        check("valid_len", 32'(val_cnt), 32'(vl));
                    end
                    val_cnt = 0;
                end
            end
        end
    end

    // Driver: directed cases first, then a randomized run, then halt and recovery.
    initial begin : driver
        logic [31:0] off;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        step();
        do_reset(1'b0);
        // R-type word, same-cycle ack, no stall: FFFFFFF8 -> FFFFFFFC
        run_instr(0, 0, 32'h0020_81B3, 1'b0, 1'b0, 32'd0);
        // Sequential from FFFFFFFC wraps to 0
        run_instr(0, 0, $urandom, 1'b1, 1'b0, 32'h40);
        // Delayed ack (3) and two stall cycles: 0 -> 4
        run_instr(3, 2, $urandom, 1'b0, 1'b1, 32'h80);
        // Taken branch to 0x100, then -8 to 0xF8, back to 0x100, not-taken to 0x104
        run_instr(0, 0, $urandom, 1'b1, 1'b1, 32'h0000_00FC);
        run_instr(0, 0, $urandom, 1'b1, 1'b1, 32'hFFFF_FFF8);
        run_instr(1, 0, $urandom, 1'b1, 1'b1, 32'h0000_0008);
        run_instr(1, 1, $urandom, 1'b1, 1'b0, 32'hFFFF_FFF8);
        for (int n = 0; n < 120; n++) begin
            off = (32'($urandom_range(0, 63)) - 32'd32) << 2;
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), off);
        end
        // Reset while a request is outstanding, ack lands in IDLE
        while (mem_bus.mem_req !== 1'b1) step();
        step();
        do_reset(1'b1);
        run_instr(2, 1, $urandom, 1'b0, 1'b0, 32'd0);
        // Misaligned taken branch: sticky error, parked until reset
        run_instr(0, 0, $urandom, 1'b1, 1'b1, 32'h0000_0006);
        for (int i = 0; i < 8; i++) begin
            mem_bus.mem_ack   = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata = $urandom;
            stall             = 1'($urandom_range(0, 1));
            junk_ctrl();
            step();
        end
        check("halt_pc_held", pc, m_pc);
        mem_bus.mem_ack = 1'b0;
        do_reset(1'b0);
        run_instr(0, 0, 32'h0000_0003, 1'b0, 1'b0, 32'd0);
        step();
        step();
        check("drain_issue_q",  32'(issue_q.size()),  32'd0);
        check("drain_retire_q", 32'(retire_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin : watchdog
        #200000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
